// File: rtl/digitaler_filter.sv
// digitaler_filter: 4-tap direct-form FIR on an 8-bit unsigned stream, coefficients loaded serially after reset.
// Optional macro SATURATE_EN: unsigned output saturation instead of 8-bit wrap-around.
module digitaler_filter #(
  parameter int TAPS  = 4,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int ACC_W = 16 + $clog2(TAPS);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       h_q [TAPS];
  logic [7:0]       h_d [TAPS];
  logic [7:0]       d_q [TAPS-1];
  logic [7:0]       d_d [TAPS-1];
  logic [7:0]       uo_q, uo_d;
  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] shifted_s;
  logic [7:0]       limit_s;
  logic             unused_ena_s;

  assign unused_ena_s = ena;

  // Direct-form multiply-accumulate over the current sample and the delay line
  always_comb begin
    acc_s = ACC_W'(ui_in) * ACC_W'(h_q[0]);
    for (int k = 1; k < TAPS; k++) begin
      acc_s = acc_s + ACC_W'(d_q[k-1]) * ACC_W'(h_q[k]);
    end
  end

  assign shifted_s = acc_s >> SHIFT;

`ifdef SATURATE_EN
  // Unsigned saturation to the 8-bit output range
  always_comb begin
    if (shifted_s > ACC_W'(255)) begin
      limit_s = 8'hFF;
    end else begin
      limit_s = shifted_s[7:0];
    end
  end
`else
  logic unused_hi_s;
  assign unused_hi_s = ^shifted_s[ACC_W-1:8];
  assign limit_s     = shifted_s[7:0];
`endif

  // Next-state logic: serial coefficient load, then one filter step per clock
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    d_d     = d_q;
    uo_d    = 8'h00;
    case (state_q)
      ST_LOAD: begin
        h_d[cnt_q] = uio_in;
        for (int k = 0; k < TAPS-1; k++) begin
          d_d[k] = 8'h00;
        end
        if (cnt_q == CNT_W'(TAPS-1)) begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        uo_d   = limit_s;
        d_d[0] = ui_in;
        for (int k = 1; k < TAPS-1; k++) begin
          d_d[k] = d_q[k-1];
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, coefficient, delay-line and output registers; rst_n is active-high here
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= {CNT_W{1'b0}};
      uo_q    <= 8'h00;
      for (int k = 0; k < TAPS; k++) begin
        h_q[k] <= 8'h00;
      end
      for (int k = 0; k < TAPS-1; k++) begin
        d_q[k] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uo_q    <= uo_d;
      for (int k = 0; k < TAPS; k++) begin
        h_q[k] <= h_d[k];
      end
      for (int k = 0; k < TAPS-1; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_digitaler_filter.sv
// Self-checking bench for digitaler_filter: directed reset/load/impulse/step cases plus randomized runs vs. a sum-of-products model.
module tb_digitaler_filter;

  localparam int TAPS  = 4;
  localparam int SHIFT = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run    = 0;
  int tests_failed = 0;

  int mh   [TAPS];
  int hist [TAPS];

  digitaler_filter #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mh[k]   = 0;
      hist[k] = 0;
    end
  endtask

  // y[n] = limit((sum_k h[k]*x[n-k]) >> SHIFT), with x history kept newest-first
  function automatic logic [7:0] model_step(input logic [7:0] x);
    int acc;
    for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(x);
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += mh[k] * hist[k];
    acc = acc >>> SHIFT;
`ifdef SATURATE_EN
    if (acc > 255) return 8'hFF;
    return acc[7:0];
`else
    return acc[7:0];
`endif
  endfunction

  task automatic load_coeffs(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] c [TAPS];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < TAPS; i++) begin
      uio_in = c[i];
      ui_in  = 8'($urandom_range(255, 0));
      tick();
      mh[i] = int'(c[i]);
      tests_run++;
      if (uo_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL load_edge%0d: uo_out got %h expected 00", i, uo_out);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'h55;
    model_reset();
    #1;
    tests_run++;
    if (uo_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_async: uo_out got %h expected 00", uo_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (uo_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_held%0d: uo_out got %h expected 00", i, uo_out);
      end
      tests_run++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        tests_failed++;
        $display("FAIL static_reset: uio_out/uio_oe got %h/%h expected 00/00", uio_out, uio_oe);
      end
    end
  endtask

  task automatic test_load();
    rst_n = 1'b0;
    load_coeffs(8'h01, 8'h02, 8'h02, 8'h02);
  endtask

  task automatic test_impulse();
    logic [7:0] imp_exp [6];
    logic [7:0] m;
    imp_exp = '{8'h0A, 8'h14, 8'h14, 8'h14, 8'h00, 8'h00};
    uio_in = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      ui_in = (i == 0) ? 8'h0A : 8'h00;
      tick();
      m = model_step(ui_in);
      tests_run++;
      if (uo_out !== imp_exp[i] || uo_out !== m) begin
        tests_failed++;
        $display("FAIL impulse%0d: uo_out got %h expected %h (model %h)", i, uo_out, imp_exp[i], m);
      end
      tests_run++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        tests_failed++;
        $display("FAIL static_run: uio_out/uio_oe got %h/%h expected 00/00", uio_out, uio_oe);
      end
    end
  endtask

  task automatic test_step();
    logic [7:0] m;
    ui_in = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      m = model_step(ui_in);
      tests_run++;
      if (uo_out !== m) begin
        tests_failed++;
        $display("FAIL step%0d: uo_out got %h expected %h", i, uo_out, m);
      end
    end
    ui_in = 8'h00;
    for (int i = 0; i < TAPS; i++) begin
      tick();
      m = model_step(ui_in);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] m;
    ui_in = 8'h0A;
    tick();
    m = model_step(ui_in);
    ui_in = 8'h00;
    tick();
    m = model_step(ui_in);
    tests_run++;
    if (uo_out !== m) begin
      tests_failed++;
      $display("FAIL midrun_pre: uo_out got %h expected %h", uo_out, m);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (uo_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrun_async: uo_out got %h expected 00", uo_out);
    end
    tick();
    tests_run++;
    if (uo_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrun_held: uo_out got %h expected 00", uo_out);
    end
    rst_n = 1'b0;
    load_coeffs(8'h01, 8'h02, 8'h02, 8'h02);
    ui_in = 8'hFF;
    tick();
    m = model_step(ui_in);
    tests_run++;
    if (uo_out !== m || uo_out === 8'h00) begin
      tests_failed++;
      $display("FAIL midrun_reload: uo_out got %h expected %h", uo_out, m);
    end
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int r = 0; r < 4; r++) begin
      rst_n = 1'b1;
      model_reset();
      tick();
      rst_n = 1'b0;
      load_coeffs(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                  8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      for (int i = 0; i < 60; i++) begin
        ui_in  = 8'($urandom_range(255, 0));
        uio_in = 8'($urandom_range(255, 0));
        tick();
        m = model_step(ui_in);
        tests_run++;
        if (uo_out !== m) begin
          tests_failed++;
          $display("FAIL random_r%0d_s%0d: uo_out got %h expected %h", r, i, uo_out, m);
        end
      end
    end
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_load();
    test_impulse();
    test_step();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
